// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared FSM state type and command-format constants for spi_reg_decoder
package spi_reg_pkg;
  typedef enum logic [2:0] {IDLE, CMD_WAIT, DATA_REQ, DATA_WAIT, WRITE, READ_RESP} state_t;
  localparam int CMD_WRITE_BIT = 7;
  localparam logic [6:0] ERR_COUNT_ADDR = 7'd127;
endpackage

// File: rtl/spi_reg_decoder_reg_bank.sv
// reg_bank: control register array with flat output bus and zero-on-miss combinational read
module reg_bank
  import spi_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [DATA_WIDTH-2:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH-2:0]          raddr,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);
  logic [NUM_REGS*DATA_WIDTH-1:0] r_regs;
  always_ff @(posedge clk) begin
    if (reset) r_regs <= '0;
    else for (int i = 0; i < NUM_REGS; i++)
      if (we && waddr == (DATA_WIDTH-1)'(i)) r_regs[i*DATA_WIDTH +: DATA_WIDTH] <= wdata;
  end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (raddr == (DATA_WIDTH-1)'(i)) rdata = r_regs[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign regs_out = r_regs;
endmodule

// File: rtl/spi_reg_decoder.sv
// spi_reg_decoder: SPI byte stream to register-bank accesses; SPI_DECODER_ERR_COUNT_EN adds err_count
module spi_reg_decoder
  import spi_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS = 16
) (
`ifdef SPI_DECODER_ERR_COUNT_EN
  output logic [DATA_WIDTH-1:0]          err_count,
`endif
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          rx_data,
  input  logic                           rx_empty,
  output logic                           rx_read,
  input  logic                           frame_abort,
  output logic [DATA_WIDTH-1:0]          tx_data,
  output logic                           tx_write,
  input  logic                           tx_full,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic                           busy
);
  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("spi_reg_decoder: DATA_WIDTH must be 8");
  end
  if (NUM_REGS < 1 || NUM_REGS > 128) begin : g_bad_regs
    $error("spi_reg_decoder: NUM_REGS must be 1..128");
  end
  state_t                r_state;
  logic [DATA_WIDTH-2:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data, r_tx_data, w_bank_rdata, w_rdata;
  logic                  r_rx_read, r_tx_write, r_busy, w_we;
  reg_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_bank (
    .clk(clk), .reset(reset), .we(w_we), .waddr(r_addr), .wdata(r_data),
    .raddr(r_addr), .rdata(w_bank_rdata), .regs_out(regs_out)
  );
`ifdef SPI_DECODER_ERR_COUNT_EN
  localparam logic [DATA_WIDTH-1:0] NREGS = DATA_WIDTH'(NUM_REGS);
  logic [DATA_WIDTH-1:0] r_err;
  logic w_err_addr, w_oor, w_err_ev;
  assign w_err_addr = r_addr == ERR_COUNT_ADDR;
  assign w_oor = !w_err_addr && {1'b0, r_addr} >= NREGS;
  // a read only counts as an error when the response is actually pushed
  assign w_err_ev = (r_state == WRITE && w_oor) || (r_state == READ_RESP && !tx_full && w_oor)
                 || (r_state == DATA_REQ && frame_abort);
  always_ff @(posedge clk) begin
    if (reset) r_err <= '0;
    else if (w_err_ev && r_err != '1) r_err <= r_err + 1'b1;
  end
  assign err_count = r_err;
  assign w_rdata = w_err_addr ? r_err : w_bank_rdata;
  assign w_we = r_state == WRITE && !w_err_addr;
`else
  assign w_rdata = w_bank_rdata;
  assign w_we = r_state == WRITE;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_tx_data  <= '0;
      r_rx_read  <= 1'b0;
      r_tx_write <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_read  <= 1'b0;
      r_tx_write <= 1'b0;
      case (r_state)
        IDLE: if (!rx_empty) begin
          r_rx_read <= 1'b1;
          r_state   <= CMD_WAIT;
          r_busy    <= 1'b1;
        end
        CMD_WAIT: begin
          r_addr  <= rx_data[DATA_WIDTH-2:0];
          r_state <= rx_data[CMD_WRITE_BIT] ? DATA_REQ : READ_RESP;
        end
        DATA_REQ: if (frame_abort) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else if (!rx_empty) begin
          r_rx_read <= 1'b1;
          r_state   <= DATA_WAIT;
        end
        DATA_WAIT: begin
          r_data  <= rx_data;
          r_state <= WRITE;
        end
        WRITE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        READ_RESP: if (!tx_full) begin
          r_tx_write <= 1'b1;
          r_tx_data  <= w_rdata;
          r_state    <= IDLE;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign rx_read  = r_rx_read;
  assign tx_write = r_tx_write;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
endmodule

// File: tb/tb_spi_reg_decoder.sv
// tb_spi_reg_decoder: directed stimulus with a tx-response scoreboard and rx/tx handshake monitor
module tb_spi_reg_decoder;
  logic clk = 0, reset = 1, frame_abort = 0, tx_full = 0;
  logic rx_empty, rx_read, tx_write, busy;
  logic [7:0] rx_data, tx_data;
  logic [127:0] regs_out, exp_regs = '0;
`ifdef SPI_DECODER_ERR_COUNT_EN
  logic [7:0] err_count;
`endif
  logic [7:0] mem [64];
  logic [7:0] exp_tx [$];
  int wp = 0, rp = 0, n_cmp = 0, n_err = 0, rx_cnt = 0, tx_cnt = 0, rx0, tx0;
  spi_reg_decoder #(.DATA_WIDTH(8), .NUM_REGS(16)) dut (
`ifdef SPI_DECODER_ERR_COUNT_EN
    .err_count(err_count),
`endif
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .rx_read(rx_read),
    .frame_abort(frame_abort), .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .regs_out(regs_out), .busy(busy)
  );
  always #5 clk = ~clk;
  assign rx_empty = wp == rp;
  assign rx_data = mem[rp % 64];
  always @(posedge clk) if (rx_read && rp != wp) rp <= rp + 1;
  task automatic check(string name, logic [127:0] got, logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  task automatic push(logic [7:0] b);
    mem[wp % 64] = b;
    wp++;
  endtask
  task automatic run();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 200 && (busy || !rx_empty); i++) @(negedge clk);
    check("run_idle", {busy, rx_empty}, 2'b01);
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (rx_read) begin
      rx_cnt++;
      check("rx_read_when_empty", rx_empty, 0);
    end
    if (tx_write) begin
      tx_cnt++;
      check("tx_write_when_full", tx_full, 0);
      if (exp_tx.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tx_unexpected: got %0h want none", tx_data);
      end else check("tx_data", tx_data, exp_tx.pop_front());
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    check("rst_regs", regs_out, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_strobes", {rx_read, tx_write}, 0);
`ifdef SPI_DECODER_ERR_COUNT_EN
    check("rst_err", err_count, 0);
`endif
    rx0 = rx_cnt; tx0 = tx_cnt;
    push(8'h83); push(8'h5A);
    run();
    exp_regs[31:24] = 8'h5A;
    check("wr_reg3_byte", regs_out[31:24], 8'h5A);
    check("wr_regs", regs_out, exp_regs);
    check("wr_rx_pulses", rx_cnt - rx0, 2);
    check("wr_no_tx", tx_cnt - tx0, 0);
    tx0 = tx_cnt;
    push(8'h03); exp_tx.push_back(8'h5A);
    run();
    check("rd_tx_count", tx_cnt - tx0, 1);
    tx0 = tx_cnt;
    tx_full = 1;
    push(8'h03); exp_tx.push_back(8'h5A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_busy", busy, 1);
    end
    check("bp_no_tx", tx_cnt - tx0, 0);
    tx_full = 0;
    @(negedge clk);
    check("bp_tx_first_cycle", tx_write, 1);
    run();
    check("bp_tx_count", tx_cnt - tx0, 1);
    rx0 = rx_cnt;
    push(8'h85);
    repeat (20) @(negedge clk);
    check("ab_busy_starved", busy, 1);
    check("ab_rx_pulses", rx_cnt - rx0, 1);
    frame_abort = 1;
    @(negedge clk);
    frame_abort = 0;
    check("ab_idle", busy, 0);
    check("ab_regs", regs_out, exp_regs);
`ifdef SPI_DECODER_ERR_COUNT_EN
    check("ab_err", err_count, 1);
`endif
    push(8'h90); push(8'hFF);
    run();
    check("oor_wr_regs", regs_out, exp_regs);
`ifdef SPI_DECODER_ERR_COUNT_EN
    check("oor_wr_err", err_count, 2);
`endif
    push(8'h10); exp_tx.push_back(8'h00);
    run();
`ifdef SPI_DECODER_ERR_COUNT_EN
    check("oor_rd_err", err_count, 3);
    push(8'h7F); exp_tx.push_back(8'h03);
    run();
    push(8'hFF); push(8'h12);
    run();
    check("err_addr_ro", err_count, 3);
    check("err_addr_regs", regs_out, exp_regs);
`endif
    rx0 = rx_cnt;
    push(8'h81); push(8'h11); push(8'h82); push(8'h22); push(8'h01);
    exp_tx.push_back(8'h11);
    run();
    exp_regs[15:8] = 8'h11;
    exp_regs[23:16] = 8'h22;
    check("b2b_regs", regs_out, exp_regs);
    check("b2b_rx_pulses", rx_cnt - rx0, 5);
    push(8'h81); push(8'h77);
    repeat (3) @(negedge clk);
    check("rst_mid_in_data_wait", {busy, rx_read}, 2'b11);
    reset = 1;
    @(negedge clk);
    reset = 0;
    exp_regs = '0;
    check("rst_mid_regs", regs_out, exp_regs);
    check("rst_mid_busy", busy, 0);
`ifdef SPI_DECODER_ERR_COUNT_EN
    check("rst_mid_err", err_count, 0);
`endif
    repeat (5) @(negedge clk);
    check("rst_mid_regs_hold", regs_out, exp_regs);
    check("rst_mid_idle", {busy, rx_empty}, 2'b01);
    check("tx_queue_drained", exp_tx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
